// File: rtl/vfu_response_return.sv
// Demultiplexes tagged VFU responses into per-slot FIFOs with credit-gated issue; results appear one cycle after push.
// The VFU is never stalled: credits keep the FIFOs from overflowing, and each slot is drained by its own valid/ready handshake.
module vfu_rr_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

module vfu_response_return #(
  parameter int NUM_SLOTS = 4,
  parameter int TAG_W     = 2,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [TAG_W-1:0]       issue_tag,
  output logic [NUM_SLOTS-1:0]   slot_can_issue,
  input  logic                   resp_valid,
  input  logic [TAG_W-1:0]       resp_tag,
  input  logic [DATA_W-1:0]      resp_data,
  input  logic [1:0]             resp_executeIndex,
  output logic [NUM_SLOTS-1:0]   out_valid,
  input  logic [NUM_SLOTS-1:0]   out_ready,
  output logic [NUM_SLOTS*DATA_W-1:0] out_data,
  output logic [NUM_SLOTS*2-1:0] out_executeIndex,
  output logic                   err
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [NUM_SLOTS-1:0] err_set;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : gen_slot
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       occ;
    logic [DATA_W+1:0]   head;
    logic                issue_hit;
    logic                resp_hit;
    logic                pop;
    logic                push;
    logic                has_inflight;
    logic                issue_bad;
    logic                resp_bad;

    assign issue_hit    = issue_valid && (issue_tag == TAG_W'(i));
    assign resp_hit     = resp_valid && (resp_tag == TAG_W'(i));
    assign pop          = out_valid[i] && out_ready[i];
    assign has_inflight = cnt > occ;
    // A concurrent pop frees the entry this push takes, so a full FIFO can still accept.
    assign push         = resp_hit && has_inflight && ((occ != FULL) || pop);
    // Issuing at full credit is only legal when a pop returns a credit in the same cycle.
    assign issue_bad    = issue_hit && (cnt == FULL) && !pop;
    assign resp_bad     = resp_hit && !push;
    assign err_set[i]   = issue_bad || resp_bad;

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
      end else if (issue_hit && !pop && (cnt != FULL)) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !issue_hit) begin
        cnt <= cnt - CW'(1);
      end
    end

    vfu_rr_fifo #(
      .W     (DATA_W + 2),
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({resp_data, resp_executeIndex}),
      .pop       (pop),
      .head      (head),
      .count     (occ)
    );

    assign slot_can_issue[i]            = (cnt != FULL);
    assign out_valid[i]                 = (occ != '0);
    assign out_data[i*DATA_W +: DATA_W] = head[DATA_W+1:2];
    assign out_executeIndex[2*i +: 2]   = head[1:0];

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
      if (!reset) begin
        assert (!issue_bad);
        assert (!(resp_hit && has_inflight && !push));
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (|err_set) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vfu_response_return.sv
// Randomized and directed bench for vfu_response_return against a queue-based model of credits and per-slot results.
module tb_vfu_response_return;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  typedef logic [DW+1:0] ent_t;

  logic            clock;
  logic            reset;
  logic            issue_valid;
  logic [1:0]      issue_tag;
  logic [NS-1:0]   slot_can_issue;
  logic            resp_valid;
  logic [1:0]      resp_tag;
  logic [DW-1:0]   resp_data;
  logic [1:0]      resp_executeIndex;
  logic [NS-1:0]   out_valid;
  logic [NS-1:0]   out_ready;
  logic [NS*DW-1:0] out_data;
  logic [NS*2-1:0] out_executeIndex;
  logic            err;

  vfu_response_return #(
    .NUM_SLOTS(NS), .TAG_W(2), .DATA_W(DW), .DEPTH(DEPTH)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_tag        (issue_tag),
    .slot_can_issue   (slot_can_issue),
    .resp_valid       (resp_valid),
    .resp_tag         (resp_tag),
    .resp_data        (resp_data),
    .resp_executeIndex(resp_executeIndex),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_executeIndex (out_executeIndex),
    .err              (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   nvec = 0;
  int   nerr = 0;
  bit   armed = 0;
  int   cnt_m [NS];
  ent_t q_m [NS][$];
  bit   err_m;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic int inflight(input int i);
    return cnt_m[i] - q_m[i].size();
  endfunction

  function automatic bit busy();
    for (int i = 0; i < NS; i++) if (cnt_m[i] != 0) return 1;
    return 0;
  endfunction

  task automatic check_model();
    logic [NS-1:0] exp_can;
    logic [NS-1:0] exp_v;
    for (int i = 0; i < NS; i++) begin
      exp_can[i] = (cnt_m[i] < DEPTH);
      exp_v[i]   = (q_m[i].size() != 0);
    end
    chk("slot_can_issue", 64'(slot_can_issue), 64'(exp_can));
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("err", 64'(err), 64'(err_m));
    for (int i = 0; i < NS; i++) begin
      if (exp_v[i]) begin
        chk("out_data", 64'(out_data[i*DW +: DW]), 64'(q_m[i][0][DW+1:2]));
        chk("out_executeIndex", 64'(out_executeIndex[2*i +: 2]), 64'(q_m[i][0][1:0]));
      end
    end
  endtask

  // Check current outputs, apply one cycle of inputs, advance the model to match.
  task automatic cycle(input bit rst, input bit iv, input logic [1:0] itag,
                       input bit rv, input logic [1:0] rtag, input logic [DW-1:0] rdata,
                       input logic [1:0] ridx, input logic [NS-1:0] ordy);
    int inf [NS];
    bit popf [NS];
    if (armed) check_model();
    reset = rst; issue_valid = iv; issue_tag = itag;
    resp_valid = rv; resp_tag = rtag; resp_data = rdata; resp_executeIndex = ridx;
    out_ready = ordy;
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        cnt_m[i] = 0;
        q_m[i].delete();
      end
      err_m = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        inf[i]  = inflight(i);
        popf[i] = (q_m[i].size() > 0) && ordy[i];
      end
      for (int i = 0; i < NS; i++) begin
        if (popf[i]) begin
          void'(q_m[i].pop_front());
          cnt_m[i]--;
        end
      end
      if (rv) begin
        if (inf[rtag] > 0) q_m[rtag].push_back({rdata, ridx});
        else err_m = 1;
      end
      if (iv) begin
        if (cnt_m[itag] >= DEPTH) err_m = 1;
        else cnt_m[itag]++;
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input logic [NS-1:0] ordy);
    cycle(0, 0, 2'd0, 0, 2'd0, '0, 2'd0, ordy);
  endtask

  task automatic issue(input logic [1:0] t, input logic [NS-1:0] ordy);
    cycle(0, 1, t, 0, 2'd0, '0, 2'd0, ordy);
  endtask

  task automatic respond(input logic [1:0] t, input logic [DW-1:0] d, input logic [1:0] x,
                         input logic [NS-1:0] ordy);
    cycle(0, 0, 2'd0, 1, t, d, x, ordy);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && busy(); k++) begin
      int t;
      t = -1;
      for (int i = 0; i < NS; i++) if (t < 0 && inflight(i) > 0) t = i;
      if (t >= 0) respond(2'(t), $urandom, 2'($urandom_range(0, 3)), 4'hF);
      else idle(4'hF);
    end
    chk("drain_done", 64'(busy()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 0; issue_tag = 0; resp_valid = 0; resp_tag = 0;
    resp_data = 0; resp_executeIndex = 0; out_ready = 0;
    cycle(1, 0, 0, 0, 0, '0, 0, 4'h0);
    cycle(1, 0, 0, 0, 0, '0, 0, 4'h0);
    armed = 1;

    // Reset state, then a single issue keeps slot 1 issuable.
    chk("reset_can_issue", 64'(slot_can_issue), 64'hF);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_err", 64'(err), 64'h0);
    issue(2'd1, 4'h0);
    chk("one_issue_can", 64'(slot_can_issue), 64'hF);

    // Slot 2 at full credit, results held under backpressure, then drained in order.
    issue(2'd2, 4'h0);
    issue(2'd2, 4'h0);
    chk("slot2_blocked", 64'(slot_can_issue), 64'b1011);
    respond(2'd2, 32'hAAAA0001, 2'd1, 4'h0);
    respond(2'd2, 32'h55550002, 2'd2, 4'h0);
    idle(4'h0);
    chk("slot2_valid", 64'(out_valid[2]), 64'd1);
    chk("slot2_head0", 64'(out_data[2*DW +: DW]), 64'hAAAA0001);
    chk("slot2_idx0", 64'(out_executeIndex[5:4]), 64'd1);
    idle(4'b0100);
    chk("slot2_head1", 64'(out_data[2*DW +: DW]), 64'h55550002);
    chk("slot2_idx1", 64'(out_executeIndex[5:4]), 64'd2);
    idle(4'b0100);
    chk("slot2_empty", 64'(out_valid[2]), 64'd0);
    chk("slot2_reopen", 64'(slot_can_issue[2]), 64'd1);
    drain();

    // Slot 3: pop and issue in the same cycle at full credit, then refill the freed entry.
    issue(2'd3, 4'h0);
    issue(2'd3, 4'h0);
    respond(2'd3, 32'h30000001, 2'd0, 4'h0);
    respond(2'd3, 32'h30000002, 2'd1, 4'h0);
    issue(2'd3, 4'b1000);
    chk("slot3_still_full", 64'(slot_can_issue[3]), 64'd0);
    respond(2'd3, 32'h30000003, 2'd2, 4'h0);
    chk("slot3_no_err", 64'(err), 64'd0);
    chk("slot3_head", 64'(out_data[3*DW +: DW]), 64'h30000002);
    drain();

    // Random legal traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [NS-1:0] ordy;
      bit            iv;
      bit            rv;
      int            it;
      int            rt;
      ordy = 4'($urandom);
      it = $urandom_range(0, NS - 1);
      rt = $urandom_range(0, NS - 1);
      iv = ($urandom_range(0, 1) == 1) &&
           ((cnt_m[it] < DEPTH) || (q_m[it].size() > 0 && ordy[it]));
      rv = ($urandom_range(0, 1) == 1) && (inflight(rt) > 0);
      cycle(0, iv, 2'(it), rv, 2'(rt), $urandom, 2'($urandom_range(0, 3)), ordy);
    end
    chk("random_no_err", 64'(err), 64'd0);
    drain();

    // Interleaved slots 0 and 1, responses in the opposite slot order.
    issue(2'd0, 4'h0);
    issue(2'd1, 4'h0);
    issue(2'd0, 4'h0);
    issue(2'd1, 4'h0);
    respond(2'd1, 32'h11110001, 2'd1, 4'h0);
    respond(2'd0, 32'h00000A01, 2'd2, 4'h0);
    respond(2'd1, 32'h11110002, 2'd3, 4'h0);
    respond(2'd0, 32'h00000A02, 2'd0, 4'h0);
    idle(4'h0);
    chk("ilv_slot0_head", 64'(out_data[0 +: DW]), 64'h00000A01);
    chk("ilv_slot1_head", 64'(out_data[DW +: DW]), 64'h11110001);
    idle(4'b0011);
    chk("ilv_slot0_next", 64'(out_data[0 +: DW]), 64'h00000A02);
    issue(2'd0, 4'h0);

    // Reset with queued data; a stale response afterwards is an error.
    cycle(1, 0, 0, 0, 0, '0, 0, 4'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_can_issue", 64'(slot_can_issue), 64'hF);
    respond(2'd1, 32'hDEAD0001, 2'd0, 4'hF);
    chk("stale_err", 64'(err), 64'd1);
    idle(4'h0);
    idle(4'h0);

    // Unexpected response on a clean slot 0.
    cycle(1, 0, 0, 0, 0, '0, 0, 4'h0);
    respond(2'd0, 32'hBEEF0000, 2'd3, 4'hF);
    chk("unexp_no_valid", 64'(out_valid[0]), 64'd0);
    chk("unexp_err", 64'(err), 64'd1);
    issue(2'd0, 4'h0);
    idle(4'h0);
    chk("err_sticky", 64'(err), 64'd1);
    cycle(1, 0, 0, 0, 0, '0, 0, 4'h0);
    chk("err_cleared", 64'(err), 64'd0);
    idle(4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vfu_response_return.md
Name: vfu_response_return

Overview:
- Return path from a shared vector functional unit (VFU) back to the lane's execute slots. This is the opposite end of the slot-request-to-VFU channel.
- The VFU pipeline never stalls. Its responses carry the request tag, and the block demultiplexes them by tag into per-slot FIFOs with ready/valid outputs.
- Per-slot credit counters bound in-flight plus buffered results to the FIFO depth. The slot-side request path uses the slot_can_issue outputs to gate issue, so a response never finds a full FIFO.

Parameters:
- NUM_SLOTS, 4, number of execute slots; equals 2^TAG_W
- TAG_W, 2, width of the request/response tag
- DATA_W, 32, width of the result data
- DEPTH, 2, per-slot FIFO entries; also the maximum outstanding requests per slot (≥1)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  a request was accepted by the VFU this cycle (request-side valid&ready)
- issue_tag  in  TAG_W  slot tag of the accepted request
- slot_can_issue  out  NUM_SLOTS  bit i=1: slot i may issue a request this cycle
- resp_valid  in  1  VFU response valid; no backpressure
- resp_tag  in  TAG_W  destination slot
- resp_data  in  DATA_W  result
- resp_executeIndex  in  2  execute index echoed from the request
- out_valid  out  NUM_SLOTS  per-slot result valid
- out_ready  in  NUM_SLOTS  per-slot consumer ready
- out_data  out  NUM_SLOTS*DATA_W  slot i at bits [i*DATA_W +: DATA_W]
- out_executeIndex  out  NUM_SLOTS*2  slot i at bits [2i +: 2]
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (synchronous): all credit counters = 0; all FIFOs empty; out_valid = 0; slot_can_issue = all 1s; err = 0. A reset mid-operation discards queued results and in-flight accounting; responses arriving later are treated as errors.
- Credit counter cnt[i], range 0..DEPTH: counts requests issued and not yet popped from slot i's FIFO (in flight + queued).
  - +1 on issue_valid && issue_tag==i.
  - −1 on out_valid[i] && out_ready[i].
  - Both in the same cycle: unchanged.
- slot_can_issue[i] = (cnt[i] < DEPTH). Combinational from registered state only; no path from issue_valid.
- Issue when cnt[i]==DEPTH: protocol violation. cnt saturates at DEPTH, err sets; a simulation assertion fires.
- Occupancy occ[i] is the number of FIFO entries. In-flight count inflight[i] = cnt[i] − occ[i].
- Response handling: resp_valid && resp_tag==i.
  - If inflight[i] > 0: push {resp_data, resp_executeIndex} into FIFO i.
  - If inflight[i] == 0 (unexpected response): drop the response, set err.
  - Credit makes FIFO overflow impossible. A push into a full FIFO, if it ever occurs, is dropped, sets err and asserts.
- FIFO: DEPTH entries, in-order, circular read/write pointers with wrap at DEPTH.
  - Push and pop in the same cycle are allowed at any occupancy, including full (pop frees an entry, push takes it).
  - No bypass: a response pushed in cycle N gives out_valid at N+1 at the earliest.
  - out_valid[i] = (occ[i] != 0). out_data and out_executeIndex come from the head entry.
  - Outputs are stable while out_valid is high and out_ready is low.
- Slots are independent: any combination of one issue, one response and NUM_SLOTS pops in one cycle is legal. Issue and response for the same slot in the same cycle use the pre-cycle inflight value, so a response needs a request issued in an earlier cycle.
- Responses may arrive any number of cycles after issue. Ordering is preserved per slot only; responses to different slots may interleave in any order.
- err is cleared only by reset.

Test Plan:
- Reset, then idle: slot_can_issue=4'hF, out_valid=0, err=0; issue tag1 → next cycle cnt1=1, slot_can_issue=4'hF.
- Issue tag2 twice (DEPTH=2) → slot_can_issue[2]=0 until a pop. Responses 0xAAAA0001/execIdx 1 then 0x55550002/execIdx 2 arrive with out_ready[2]=0 → out_valid[2]=1 holding 0xAAAA0001. Raise out_ready[2] → 0xAAAA0001 then 0x55550002, then out_valid[2]=0 and slot_can_issue[2]=1.
- Full FIFO on slot 3 with out_ready[3]=1 and a new issue in the same cycle → cnt3 stays 2, slot_can_issue[3]=0. The following response pushes into the freed entry; no err.
- resp_valid with tag0 and no prior issue → out_valid[0] stays 0, err=1 next cycle and stays 1 until reset.
- Interleaved: issue tags 0,1,0,1, responses in order 1,0,1,0 with distinct data → each slot outputs its own data in per-slot order; no cross-slot leakage.
- Assert reset while slots 0 and 1 hold data → next cycle all out_valid=0 and cnt all 0; a stale response afterwards sets err.
